// File: rtl/uart_rx.sv
// uart_rx: 8N1 debug UART receiver with a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN for 8E1 framing; this adds the parity_err pulse output.
module uart_rx #(
    parameter int CLK_HZ = 24000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    // START is entered one clock after the synchronized edge; preload so the
    // start-bit sample still lands CLKS_PER_BIT/2 clocks after that edge.
    localparam logic [CW-1:0] CNT_START = CW'(CLKS_PER_BIT - CLKS_PER_BIT / 2 + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state, state_next;
    logic          sync1, line, line_d;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    idx, idx_next;
    logic [7:0]    shift, shift_next;
    logic          done, done_next;
    logic          ferr_next;
`ifdef UART_RX_PARITY_EN
    logic          perr_next;
`endif
    logic          fall, tick;

    assign fall = line_d & ~line;
    assign tick = (cnt == CNT_LAST);
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b1;
            line   <= 1'b1;
            line_d <= 1'b1;
        end else begin
            sync1  <= rx;
            line   <= sync1;
            line_d <= line;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            done       <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            idx        <= idx_next;
            shift      <= shift_next;
            done       <= done_next;
            frame_err  <= ferr_next;
`ifdef UART_RX_PARITY_EN
            parity_err <= perr_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shift_next = shift;
        done_next  = 1'b0;
        ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_next  = 1'b0;
`endif
        if (state != S_IDLE && state != S_BREAK) begin
            cnt_next = tick ? '0 : cnt + 1'b1;
        end
        case (state)
            S_IDLE: begin
                if (fall) begin
                    state_next = S_START;
                    cnt_next   = CNT_START;
                end
            end
            S_START: begin
                if (tick) begin
                    idx_next   = '0;
                    state_next = line ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_next[idx] = line;
                    if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end else begin
                        idx_next = idx + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    perr_next  = ^{shift, line};
                    state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (line) begin
                        done_next  = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (line) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // A completed byte may replace the held one only when it is consumed in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven, directed and randomized checks of uart_rx at 10 clocks per bit.
// Honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx;

    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 100000;
    localparam int CPB    = CLK_HZ / BAUD;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1 + CPB;
`else
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         rises = 0, ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0, busy_cnt = 0;
    int         last_rise = 0;
    logic       valid_d = 1'b0;
    logic [7:0] xfer_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observer: counts pulses and logs every byte actually handed over.
    always @(negedge clk) begin
        valid_d <= rx_valid;
        if (rx_valid === 1'b1 && valid_d !== 1'b1) begin
            rises     <= rises + 1;
            last_rise <= cyc;
        end
        if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
        if (overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;
        if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
`ifdef UART_RX_PARITY_EN
        if (parity_err === 1'b1) perr_cnt <= perr_cnt + 1;
`endif
        if (rx_valid === 1'b1 && rx_ready === 1'b1) xfer_q.push_back(rx_data);
    end

    int checks = 0;
    int failures = 0;
    int start_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        if (n != 0) #1;
    endtask

    // Called 1 time unit after a rising edge; leaves the line at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        start_cyc = cyc;
        rx = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clks(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ par_flip;
        wait_clks(CPB);
`else
        if (par_flip) wait_clks(0);
`endif
        rx = stop_bit;
        wait_clks(CPB);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_valid;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] exp_q[$];
    int         r0, f0, o0, p0, b0, x0, exp_ferr;

    initial begin
        vecs[0] = '{8'h55, 1'b1, 1, 8'h55, 0};
        vecs[1] = '{8'h00, 1'b1, 1, 8'h00, 0};
        vecs[2] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
        vecs[3] = '{8'h81, 1'b0, 0, 8'h00, 1};
        vecs[4] = '{8'hA5, 1'b1, 1, 8'hA5, 0};

        rst_n    = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_data", rx_data, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;
        wait_clks(3);

        // Table-driven single frames, consumer always ready.
        rx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            r0 = rises; f0 = ferr_cnt; o0 = ovr_cnt;
            send_frame(vecs[i].data, vecs[i].stop, 1'b0);
            rx = 1'b1;
            wait_clks(2 * CPB);
            check($sformatf("vec%0d_valid_count", i), rises - r0, vecs[i].exp_valid);
            check($sformatf("vec%0d_frame_err", i), ferr_cnt - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d_overrun", i), ovr_cnt - o0, 0);
            if (vecs[i].exp_valid != 0) begin
                check($sformatf("vec%0d_latency", i), last_rise - start_cyc, LAT);
                check($sformatf("vec%0d_data", i), xfer_q[$], vecs[i].exp_data);
            end
        end

        // Back-to-back frames with nobody consuming: second byte overruns.
        rx_ready = 1'b0;
        r0 = rises; o0 = ovr_cnt; x0 = xfer_q.size();
        send_frame(8'hA3, 1'b1, 1'b0);
        send_frame(8'h0F, 1'b1, 1'b0);
        wait_clks(5);
        check("ovr_pulses", ovr_cnt - o0, 1);
        check("ovr_valid_rises", rises - r0, 1);
        check("ovr_held_data", rx_data, 8'hA3);
        check("ovr_valid_held", rx_valid, 1);
        rx_ready = 1'b1;
        wait_clks(1);
        rx_ready = 1'b0;
        check("ovr_valid_cleared", rx_valid, 0);
        check("ovr_xfer_count", xfer_q.size() - x0, 1);
        check("ovr_xfer_data", xfer_q[$], 8'hA3);

        // Bad stop bit followed by a long break.
        r0 = rises; f0 = ferr_cnt;
        send_frame(8'h81, 1'b0, 1'b0);
        wait_clks(50 * CPB);
        check("break_frame_err", ferr_cnt - f0, 1);
        check("break_no_valid", rises - r0, 0);
        check("break_busy", busy, 1);
        rx = 1'b1;
        wait_clks(2 * CPB);
        rx_ready = 1'b1;
        send_frame(8'h42, 1'b1, 1'b0);
        wait_clks(3);
        check("after_break_data", xfer_q[$], 8'h42);
        check("after_break_latency", last_rise - start_cyc, LAT);

        // Three-clock glitch on the idle line.
        r0 = rises; f0 = ferr_cnt; o0 = ovr_cnt; b0 = busy_cnt;
        rx = 1'b0;
        wait_clks(3);
        rx = 1'b1;
        wait_clks(20);
        check("glitch_busy_bounded", (busy_cnt - b0 >= 1) && (busy_cnt - b0 <= 7), 1);
        check("glitch_no_pulses", (rises - r0) + (ferr_cnt - f0) + (ovr_cnt - o0), 0);
        check("glitch_idle", busy, 0);

        // Reset in the middle of the data bits of 0xFF.
        f0 = ferr_cnt;
        rx = 1'b0;
        wait_clks(CPB);
        rx = 1'b1;
        wait_clks(3 * CPB);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_rx_valid", rx_valid, 0);
        check("midreset_rx_data", rx_data, 0);
        check("midreset_frame_err", frame_err, 0);
        check("midreset_overrun", overrun, 0);
        @(posedge clk);
        #1;
        wait_clks(2);
        rst_n = 1'b1;
        wait_clks(2 * CPB);
        send_frame(8'h3C, 1'b1, 1'b0);
        wait_clks(3);
        check("midreset_recover_data", xfer_q[$], 8'h3C);
        check("midreset_recover_latency", last_rise - start_cyc, LAT);
        check("midreset_no_frame_err", ferr_cnt - f0, 0);

`ifdef UART_RX_PARITY_EN
        p0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b0);
        wait_clks(3);
        check("parity_ok_data", xfer_q[$], 8'h07);
        check("parity_ok_no_err", perr_cnt - p0, 0);
        send_frame(8'h07, 1'b1, 1'b1);
        wait_clks(3);
        check("parity_bad_data", xfer_q[$], 8'h07);
        check("parity_bad_err", perr_cnt - p0, 1);
`endif

        // Random frames: good stop bits deliver in order, bad ones give one frame_err each.
        f0 = ferr_cnt; o0 = ovr_cnt; p0 = perr_cnt; x0 = xfer_q.size();
        exp_ferr = 0;
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            logic       bad;
            int         gap;
            d   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 4) == 0);
            gap = bad ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 2));
            send_frame(d, !bad, 1'b0);
            if (bad) exp_ferr++;
            else exp_q.push_back(d);
            rx = 1'b1;
            wait_clks(gap * CPB);
        end
        wait_clks(3 * CPB);
        check("rand_xfer_count", xfer_q.size() - x0, exp_q.size());
        check("rand_frame_err", ferr_cnt - f0, exp_ferr);
        check("rand_overrun", ovr_cnt - o0, 0);
        check("rand_parity_err", perr_cnt - p0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (x0 + i < xfer_q.size())
                check($sformatf("rand_byte%0d", i), xfer_q[x0 + i], exp_q[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
